if_id_skid_stage: RTL
=====================

// Module: if_id_skid_stage
// PURPOSE
//  Parametrised IF/ID pipeline stage with valid/ready handshake and a 2-entry skid
//  buffer. Replaces the single stall/flush register between fetch and decode; lets
//  fetch keep streaming for one cycle after decode deasserts ready.
//  Adds flush-to-NOP, a valid qualifier and a saturating stall-cycle counter.
// PARAMETERS
//  PC_W       32            width of pc4 field
//  INSTR_W    32            width of instruction field
//  NOP_INSTR  {INSTR_W{0}}  instr_o value when stage empty or flushed
//  CNT_W      16            width of stall_cnt_o (saturating)
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_i        in   1        async reset, active-high
//  valid_i      in   1        fetch presents pc4_i/instr_i
//  ready_o      out  1        stage accepts input this cycle
//  pc4_i        in   PC_W     fetched PC+4
//  instr_i      in   INSTR_W  fetched instruction
//  flush_i      in   1        branch/jump flush; kills all held and incoming entries
//  valid_o      out  1        pc4_o/instr_o hold a live instruction
//  ready_i      in   1        decode consumes output this cycle
//  pc4_o        out  PC_W     head entry PC+4 (0 when !valid_o)
//  instr_o      out  INSTR_W  head entry instruction (NOP_INSTR when !valid_o)
//  stall_cnt_o  out  CNT_W    cycles with valid_o & !ready_i since reset
// BEHAVIOUR
//  - Storage: main reg (drives outputs) + skid reg. State EMPTY / FULL / SKID.
//  - in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
//  - ready_o = (state != SKID), combinational from state only (no path from ready_i).
//  - valid_o = (state != EMPTY); pc4_o/instr_o taken straight from main reg, which
//    is written to 0/NOP_INSTR whenever the stage goes EMPTY.
//  - EMPTY: in_fire -> main<=in, FULL; else stay.
//  - FULL : in&out -> main<=in, FULL; in&!out -> skid<=in, SKID;
//           !in&out -> main<=0/NOP, EMPTY; neither -> hold, FULL.
//  - SKID : ready_o=0; ready_i -> main<=skid, FULL; else hold all.
//  - Latency: 1 cycle valid_i->valid_o from EMPTY; order strictly preserved.
//  - flush_i (sync, highest priority): next state EMPTY, main<=0/NOP, skid cleared;
//    any in_fire in the same cycle is dropped; out_fire in that cycle still counts
//    as consumed by decode (decode owns its own flush).
//  - stall_cnt_o: +1 each cycle valid_o & !ready_i & !flush_i; saturates at
//    2^CNT_W-1; never wraps; cleared only by reset.
//  - Reset (async, any cycle incl. mid-transfer): state EMPTY, valid_o=0, ready_o=1,
//    pc4_o=0, instr_o=NOP_INSTR, skid cleared, stall_cnt_o=0. First accept on the
//    first rising edge after rst_i falls.
//  - No X propagation: held regs are never loaded when their enable is low.
// TESTING
//  1 Stream: ready_i=1, valid_i=1, instr 0x11..0x15 over 5 cycles -> instr_o
//    0x11..0x15 one cycle later, valid_o=1 throughout, ready_o never 0, cnt=0.
//  2 Skid: in FULL(0xA1), ready_i=0 while valid_i=1 with 0xA2 -> SKID, ready_o=0;
//    ready_i=1 next two cycles -> outputs 0xA1 then 0xA2, then ready_o=1.
//  3 Flush: SKID holding 0xB1/0xB2, flush_i=1 with valid_i=1 (0xB3) -> next cycle
//    valid_o=0, instr_o=NOP_INSTR, pc4_o=0, ready_o=1; 0xB3 never appears.
//  4 Stall counter: CNT_W=4, valid_o=1, ready_i=0 for 20 cycles -> stall_cnt_o
//    counts 1..15 and holds 15; flush cycles not counted.
//  5 Async reset mid-SKID: assert rst_i between edges -> outputs go to reset values
//    immediately, before next edge; release -> accept 0xC1 next edge, valid_o=1.
//  6 Random valid_i/ready_i/flush_i 10k cycles vs. scoreboard queue -> no loss,
//    duplication or reorder except entries killed by flush.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with valid/ready handshake, a 2-entry skid buffer,
// synchronous flush-to-NOP and a saturating stall-cycle counter.
module if_id_skid_stage #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [PC_W-1:0]    pc4_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [PC_W-1:0]    pc4_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0]   main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic                 main_ld, skid_ld;
  logic [CNT_W-1:0]     cnt_q;
  logic                 in_fire, out_fire;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    main_ld      = 1'b0;
    main_pc_d    = '0;
    main_instr_d = NOP_INSTR;
    skid_ld      = 1'b0;
    skid_pc_d    = '0;
    skid_instr_d = NOP_INSTR;
    if (flush_i) begin
      // Flush kills everything held and any same-cycle accept.
      state_d = EMPTY;
      main_ld = 1'b1;
      skid_ld = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d      = FULL;
          main_ld      = 1'b1;
          main_pc_d    = pc4_i;
          main_instr_d = instr_i;
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_ld      = 1'b1;
            main_pc_d    = pc4_i;
            main_instr_d = instr_i;
          end else if (in_fire) begin
            state_d      = SKID;
            skid_ld      = 1'b1;
            skid_pc_d    = pc4_i;
            skid_instr_d = instr_i;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_ld = 1'b1;
          end
        end
        SKID: if (ready_i) begin
          state_d      = FULL;
          main_ld      = 1'b1;
          main_pc_d    = skid_pc_q;
          main_instr_d = skid_instr_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    ready_o = (state_q != SKID);
    valid_o = (state_q != EMPTY);
    pc4_o   = main_pc_q;
    instr_o = main_instr_q;
  end

  // NOTE: the data registers are reset too, because the outputs are driven
  // straight from the main register and must read 0/NOP while in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      if (main_ld) begin
        main_pc_q    <= main_pc_d;
        main_instr_q <= main_instr_d;
      end
      if (skid_ld) begin
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (valid_o && !ready_i && !flush_i && cnt_q != CNT_MAX)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign stall_cnt_o = cnt_q;

endmodule
